// File: rtl/intc_pkg.sv
// ============================================================================
// Module  : intc_pkg
// Brief   : Shared constants and state encoding for the IRQ sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package intc_pkg;

    localparam int c_nsrc = 4;
    localparam int c_id_w = $clog2(c_nsrc);

    localparam logic [c_nsrc-1:0] c_default_mask = {c_nsrc{1'b1}};

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_req     = 2'd1;
    localparam logic [1:0] c_st_service = 2'd2;

endpackage

`default_nettype wire

// File: rtl/intc_prio_pick.sv
// ============================================================================
// Module  : intc_prio_pick
// Brief   : Combinational picker; first eligible source found scanning
//           upward (with wrap) from the start index.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_prio_pick
    import intc_pkg::*;
#(
    parameter  int NSRC = c_nsrc,
    localparam int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] eligible,
    input  logic [IDW-1:0]  start,
    output logic [IDW-1:0]  winner,
    output logic            valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (!valid && eligible[(int'(start) + i) % NSRC]) begin
                winner = IDW'((int'(start) + i) % NSRC);
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intc_irq_sequencer.sv
// ============================================================================
// Module  : intc_irq_sequencer
// Brief   : Latches done edges into pending bits, arbitrates among enabled
//           sources and runs the IRQ / IACK / EOI handshake with the CPU.
// Options : INTC_ROUND_ROBIN_EN - round-robin arbitration (default: fixed,
//           lowest index wins)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_irq_sequencer
    import intc_pkg::*;
#(
    parameter  int NSRC = c_nsrc,
    parameter  int AW   = 32,
    localparam int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   done,
    input  logic [NSRC*AW-1:0] isr_table,
    input  logic              mask_we,
    input  logic [NSRC-1:0]   mask_wdata,
    input  logic              iack,
    input  logic              eoi,
    output logic              irq,
    output logic [AW-1:0]     isr_addr,
    output logic [IDW-1:0]    active_id,
    output logic [NSRC-1:0]   pending,
    output logic              overrun
);

    localparam logic [NSRC-1:0] c_mask_rst = {NSRC{1'b1}};

    logic [1:0]      r_state;
    logic [NSRC-1:0] r_done_q;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic            r_irq;
    logic            r_overrun;
    logic [AW-1:0]   r_isr_addr;
    logic [IDW-1:0]  r_active_id;

    logic [AW-1:0]   w_tbl [NSRC];
    logic [NSRC-1:0] w_act_bit;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_svc_bit;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_eligible;
    logic [IDW-1:0]  w_start;
    logic [IDW-1:0]  w_winner;
    logic            w_valid;
    logic            w_take_ack;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_tbl[gi]     = isr_table[gi*AW +: AW];
            assign w_act_bit[gi] = (r_active_id == IDW'(gi));
        end
    endgenerate

    assign w_rise     = done & ~r_done_q;
    assign w_take_ack = (r_state == c_st_req) && iack;
    assign w_clr      = w_take_ack ? w_act_bit : '0;
    assign w_svc_bit  = (r_state == c_st_service) ? w_act_bit : '0;
    // A new edge outranks the acknowledge clear on the same bit.
    assign w_pend_nxt = (r_pending & ~w_clr) | w_rise;
    assign w_eligible = r_pending & r_mask;

`ifdef INTC_ROUND_ROBIN_EN
    logic [IDW-1:0] r_ptr;

    // Pointer holds the last granted ID; the search begins just past it.
    assign w_start = (r_ptr == IDW'(NSRC-1)) ? '0 : r_ptr + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IDW'(NSRC-1);
        end else if (w_take_ack) begin
            r_ptr <= r_active_id;
        end
    end
`else
    assign w_start = '0;
`endif

    intc_prio_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .eligible (w_eligible),
        .start    (w_start),
        .winner   (w_winner),
        .valid    (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_done_q    <= done;
            r_pending   <= '0;
            r_mask      <= c_mask_rst;
            r_irq       <= 1'b0;
            r_overrun   <= 1'b0;
            r_isr_addr  <= '0;
            r_active_id <= '0;
        end else begin
            r_done_q  <= done;
            r_pending <= w_pend_nxt;
            r_overrun <= |(w_rise & ((r_pending & ~w_clr) | w_svc_bit));
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_valid) begin
                        r_active_id <= w_winner;
                        r_isr_addr  <= w_tbl[w_winner];
                        r_irq       <= 1'b1;
                        r_state     <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (iack) begin
                        r_irq   <= 1'b0;
                        r_state <= c_st_service;
                    end
                end
                c_st_service: begin
                    if (eoi) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign irq       = r_irq;
    assign isr_addr  = r_isr_addr;
    assign active_id = r_active_id;
    assign pending   = r_pending;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: doc/intc_irq_sequencer.md
Name: intc_irq_sequencer

Overview:
- Sequences interrupt delivery between the per-core done lines and the CPU's IRQ/IACK handshake.
- Latches done pulses into pending bits and applies a software enable mask.
- Selects one pending source, raises IRQ, and presents that source's ISR address from the ISR address table.
- Holds the source in service until software signals end-of-interrupt; sits between the ISR address registers and the CPU interrupt inputs.

Parameters:
- NSRC, 4, number of interrupt sources; ID width is clog2(NSRC).
- AW, 32, ISR address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- done  input  NSRC  per-source request; rising edge sets pending
- isr_table  input  NSRC*AW  ISR address table; slice i holds the ISR address for source i
- mask_we  input  1  write strobe for the enable mask
- mask_wdata  input  NSRC  new enable mask; 1 = source enabled
- iack  input  1  CPU interrupt acknowledge, single-cycle pulse
- eoi  input  1  end-of-interrupt strobe from software, single-cycle pulse
- irq  output  1  interrupt request to the CPU
- isr_addr  output  AW  ISR address of the granted source
- active_id  output  clog2(NSRC)  ID of the granted or in-service source
- pending  output  NSRC  latched pending bits, readable by software
- overrun  output  1  one-cycle pulse when a done edge hits an already-pending source

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, pending=0, mask=all ones, irq=0, isr_addr=0, active_id=0, overrun=0.
  - The done-edge history register is cleared to the current done value, so levels already high at reset do not create requests.
  - Reset mid-handshake abandons the in-service source without further output.
- Edge detect: done_q registers done each cycle; rise = done & ~done_q. pending[i] sets on rise[i].
- Overrun: a rise on a bit already pending (or on the in-service source) pulses overrun for 1 cycle; no counting.
- Mask write: mask_we loads the mask next edge. Masked sources still latch pending; they are not eligible.
- Eligibility: eligible = pending & mask.
- Arbitration: fixed priority, lowest index wins.
- FSM:
  - IDLE: if eligible != 0, latch winner into active_id, set isr_addr = isr_table slice of the winner, assert irq next cycle, go REQ. Request-to-irq latency is 2 cycles from the done edge (1 cycle to pending, 1 to irq).
  - REQ: irq held high; isr_addr and active_id frozen even if isr_table or the mask changes. On iack: irq=0, clear pending[active_id], go SERVICE. Masking the active source while in REQ does not withdraw the request.
  - SERVICE: irq=0; new edges only set pending. On eoi: go IDLE. A pending eligible source re-raises irq 1 cycle after returning to IDLE (no nesting).
- Simultaneous events:
  - Set (rise) in the same cycle as clear (iack) on the same bit: set wins, pending stays 1 and overrun is not pulsed.
  - iack in IDLE or SERVICE and eoi in IDLE or REQ are ignored.
  - iack and eoi together in REQ: iack is taken and eoi is ignored.

Optional Feature:
- INTC_ROUND_ROBIN_EN defined: arbitration is round-robin.
  - The search starts at (last granted ID + 1) mod NSRC; the pointer updates on iack.
  - After reset the pointer is 0, so the search starts at ID 0 (pointer reset value = NSRC-1).
- Undefined: fixed lowest-index priority, no pointer register.

Decomposition:
- Shared package intc_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2);
  - the NSRC/ID width constants;
  - the default mask constant.
- One sub-module: intc_prio_pick, a combinational picker. Inputs are the eligible vector and the start pointer; outputs are the winner ID and a valid flag. Fixed priority ties the start pointer to 0.

Test Plan:
- Single source: mask default, pulse done[2] -> irq=1 two cycles later, isr_addr=isr_table[2]; then iack -> irq=0, pending=4'b0000; then eoi -> IDLE.
- Priority: done[3] and done[1] rise in the same cycle -> grant ID1 first. After iack+eoi, ID3 is granted and irq re-rises 1 cycle after eoi. With INTC_ROUND_ROBIN_EN, after grants to 1 then 3, a repeat of 1+3 grants ID1 again, per the pointer order.
- Mask: write mask=4'b1110 then pulse done[0] -> pending[0]=1, irq stays 0. Then write mask=4'b1111 -> irq=1 with active_id=0.
- Overrun/collision: done[1] edge while pending[1]=1 -> overrun pulse 1 cycle. done[1] edge in the same cycle as iack for ID1 -> pending[1] remains 1, no overrun.
- Table freeze: change isr_table slice 0 from 0x00000100 to 0x00000200 while in REQ for ID0 -> isr_addr stays 0x00000100 until the next grant.
- Reset mid-operation: assert rst in SERVICE with pending=4'b0100 -> next cycle irq=0, pending=0, mask=4'b1111, state=IDLE; stray iack/eoi then produce no response.
